intr_entry_sequencer: RTL

- Consumes the latched interrupt flag from the ports/interrupt block and carries out the CPU interrupt-entry sequence.
- Sequence: waits for an instruction boundary, stalls and drains the pipeline, pushes the return PC onto the stack, fetches the ISR vector from memory, loads the PC, then pulses intr_clear back to the ports block.
- Sits in the control unit, between the ports/interrupt block and the fetch/stack/memory-arbitration logic.

---
 rtl/intr_entry_sequencer.sv | 135 +++++++++++++
 1 files changed

// File: rtl/intr_entry_sequencer.sv
// Interrupt-entry sequencer: waits for an instruction boundary, drains the pipeline,
// pushes the return PC, fetches the ISR vector and loads it into the PC.
module intr_entry_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [7:0]  VEC_ADDR     = 8'h01,
    parameter int unsigned MEM_LAT      = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       intr_flag,
    input  logic       hlt_flag,
    input  logic       instr_boundary,
    input  logic       rti_done,
    input  logic [7:0] pc_current,
    input  logic [7:0] sp,
    input  logic [7:0] mem_rdata,
    output logic       stall,
    output logic       flush,
    output logic       mem_we,
    output logic       mem_re,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    output logic       sp_dec,
    output logic       pc_load,
    output logic [7:0] pc_next,
    output logic       intr_clear,
    output logic       in_isr,
    output logic       busy
);

    typedef enum logic [2:0] {StIdle, StDrain, StPush, StVreq, StVwait, StLoad} state_e;

    state_e     state_q, state_d;
    logic [3:0] drain_cnt_q, drain_cnt_d;
    logic [1:0] lat_cnt_q, lat_cnt_d;
    logic [7:0] saved_pc_q, saved_pc_d;
    logic       in_isr_q, in_isr_d;
    logic       trigger;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            drain_cnt_q <= 4'd0;
            lat_cnt_q   <= 2'd0;
            saved_pc_q  <= 8'h00;
            in_isr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            lat_cnt_q   <= lat_cnt_d;
            saved_pc_q  <= saved_pc_d;
            in_isr_q    <= in_isr_d;
        end
    end

    assign trigger = intr_flag & ~in_isr_q & (instr_boundary | hlt_flag);

    always_comb begin
        state_d     = state_q;
        drain_cnt_d = drain_cnt_q;
        lat_cnt_d   = lat_cnt_q;
        saved_pc_d  = saved_pc_q;
        in_isr_d    = in_isr_q;
        stall       = 1'b0;
        flush       = 1'b0;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
        mem_addr    = 8'h00;
        mem_wdata   = 8'h00;
        sp_dec      = 1'b0;
        pc_load     = 1'b0;
        pc_next     = 8'h00;
        intr_clear  = 1'b0;
        busy        = (state_q != StIdle);

        // LOAD below overrides a coincident RTI, which cannot occur inside a sequence anyway
        if (in_isr_q && rti_done) begin
            in_isr_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (trigger) begin
                    saved_pc_d  = pc_current;
                    drain_cnt_d = 4'(DRAIN_CYCLES - 1);
                    state_d     = StDrain;
                end
            end
            StDrain: begin
                stall       = 1'b1;
                flush       = 1'b1;
                drain_cnt_d = drain_cnt_q - 4'd1;
                if (drain_cnt_q == 4'd0) begin
                    state_d = StPush;
                end
            end
            StPush: begin
                stall     = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = sp;
                mem_wdata = saved_pc_q;
                sp_dec    = 1'b1;
                state_d   = StVreq;
            end
            StVreq: begin
                stall     = 1'b1;
                mem_re    = 1'b1;
                mem_addr  = VEC_ADDR;
                lat_cnt_d = 2'(MEM_LAT - 1);
                state_d   = (MEM_LAT == 1) ? StLoad : StVwait;
            end
            StVwait: begin
                stall     = 1'b1;
                mem_re    = 1'b1;
                mem_addr  = VEC_ADDR;
                lat_cnt_d = lat_cnt_q - 2'd1;
                if (lat_cnt_q == 2'd1) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                stall      = 1'b1;
                pc_load    = 1'b1;
                pc_next    = mem_rdata;
                intr_clear = 1'b1;
                in_isr_d   = 1'b1;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign in_isr = in_isr_q;

endmodule
